// File: rtl/chacha_pkg.sv
// chacha_pkg: shared widths, FSM states, quarter-round index tables and rotate helper
package chacha_pkg;
  localparam int W = 32;
  localparam int N = 16;
  localparam int R = 20;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;
  // nibble k holds the state index feeding quarter-round slot k (k=4*qr+{a,b,c,d})
  localparam logic [63:0] COL  = 64'hfb73ea62d951c840;
  localparam logic [63:0] DIAG = 64'he943d872cb61fa50;
  function automatic logic [W-1:0] rotl32(input logic [W-1:0] v, input int n);
    return (v << n) | (v >> (W - n));
  endfunction
endpackage

// File: rtl/chacha_qr.sv
// chacha_qr: combinational ChaCha quarter-round
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] ya,
  output logic [W-1:0] yb,
  output logic [W-1:0] yc,
  output logic [W-1:0] yd
);
  logic [W-1:0] a1, b1, c1, d1;
  assign a1 = a + b;
  assign d1 = rotl32(d ^ a1, 16);
  assign c1 = c + d1;
  assign b1 = rotl32(b ^ c1, 12);
  assign ya = a1 + b1;
  assign yd = rotl32(d1 ^ ya, 8);
  assign yc = c1 + yd;
  assign yb = rotl32(b1 ^ yc, 7);
endmodule

// File: rtl/chacha20_decrypt.sv
// chacha20_decrypt: iterative ChaCha20 block, one round per cycle, XORs keystream onto ciphertext
module chacha20_decrypt
  import chacha_pkg::*;
#(
  parameter logic [W-1:0] C0 = 32'h00000001,
  parameter logic [W-1:0] C1 = 32'h00000001,
  parameter logic [W-1:0] C2 = 32'h00000001,
  parameter logic [W-1:0] C3 = 32'h00000001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic [511:0] ciphertext,
  output logic [511:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready
);
  logic [W-1:0] x [N];
  logic [W-1:0] s [N];
  logic [W-1:0] init [N];
  logic [W-1:0] qi [N];
  logic [W-1:0] qo [N];
  logic [W-1:0] y [N];
  logic [511:0] ct;
  logic [63:0]  tbl;
  logic [4:0]   round_cnt;
  logic         load;
  state_t       state, nxt;
  assign in_ready = state == IDLE || (state == OUT && out_ready);
  assign load = in_valid && in_ready;
  assign tbl = round_cnt[0] ? DIAG : COL;
  always_comb begin
    init[0] = C0;
    init[1] = C1;
    init[2] = C2;
    init[3] = C3;
    for (int i = 0; i < 8; i++) init[4+i] = key[255-32*i -: 32];
    init[12] = counter;
    for (int i = 0; i < 3; i++) init[13+i] = nonce[95-32*i -: 32];
  end
  always_comb begin
    for (int i = 0; i < N; i++) qi[i] = x[tbl[4*i +: 4]];
  end
  for (genvar q = 0; q < 4; q++) begin : g_qr
    chacha_qr u_qr (
      .a(qi[4*q]), .b(qi[4*q+1]), .c(qi[4*q+2]), .d(qi[4*q+3]),
      .ya(qo[4*q]), .yb(qo[4*q+1]), .yc(qo[4*q+2]), .yd(qo[4*q+3])
    );
  end
  always_comb begin
    y = x;
    for (int i = 0; i < N; i++) y[tbl[4*i +: 4]] = qo[i];
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = load ? ROUND : IDLE;
      ROUND:   nxt = round_cnt == 5'(R - 1) ? FINAL : ROUND;
      FINAL:   nxt = OUT;
      OUT:     nxt = out_ready ? (in_valid ? ROUND : IDLE) : OUT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      round_cnt <= '0;
      out_valid <= 1'b0;
      plaintext <= '0;
    end else begin
      state <= nxt;
      if (load) begin
        x <= init;
        s <= init;
        ct <= ciphertext;
        round_cnt <= '0;
      end else if (state == ROUND) begin
        x <= y;
        round_cnt <= round_cnt + 5'd1;
      end
      if (state == FINAL) begin
        for (int i = 0; i < N; i++) plaintext[511-32*i -: 32] <= ct[511-32*i -: 32] ^ (x[i] + s[i]);
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_chacha20_decrypt.sv
// tb_chacha20_decrypt: scoreboard bench with an independent ChaCha20 block model
module tb_chacha20_decrypt;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [255:0] key = '0;
  logic [95:0] nonce = '0;
  logic [31:0] counter = '0;
  logic [511:0] ciphertext = '0, plaintext;
  int total = 0, bad = 0;
  logic [511:0] sb [$];
  logic [511:0] sb_exp, last_pt;
  time acc_t;
  localparam logic [255:0] RK = 256'h03020100_07060504_0b0a0908_0f0e0d0c_13121110_17161514_1b1a1918_1f1e1d1c;
  localparam logic [95:0] RN = 96'h09000000_4a000000_00000000;

  always #5 clk = ~clk;

  chacha20_decrypt #(.C0(32'h61707865), .C1(32'h3320646e), .C2(32'h79622d32), .C3(32'h6b206574)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key), .nonce(nonce),
    .counter(counter), .ciphertext(ciphertext), .plaintext(plaintext), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic logic [127:0] qrf(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ks(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    logic [31:0] st [16];
    logic [31:0] x [16];
    logic [511:0] r;
    int qt [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                      '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    st[0] = 32'h61707865; st[1] = 32'h3320646e; st[2] = 32'h79622d32; st[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) st[4+i] = k[255-32*i -: 32];
    st[12] = c;
    for (int i = 0; i < 3; i++) st[13+i] = n[95-32*i -: 32];
    x = st;
    for (int r2 = 0; r2 < 10; r2++)
      for (int j = 0; j < 8; j++)
        {x[qt[j][0]], x[qt[j][1]], x[qt[j][2]], x[qt[j][3]]} = qrf(x[qt[j][0]], x[qt[j][1]], x[qt[j][2]], x[qt[j][3]]);
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + st[i];
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      last_pt = plaintext;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h exp=none", plaintext);
      end else begin
        sb_exp = sb.pop_front();
        if (plaintext !== sb_exp) begin
          bad++;
          $display("FAIL sb_data got=%h exp=%h", plaintext, sb_exp);
        end
      end
    end
  end

  task automatic send(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c, input logic [511:0] ct);
    int w = 0;
    key = k; nonce = n; counter = c; ciphertext = ct; in_valid = 1;
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk); #1; w++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
    end else sb.push_back(ks(k, n, c) ^ ct);
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk); n++;
    end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL out_timeout out_valid=%b exp=1", out_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (plaintext !== '0) begin bad++; $display("FAIL reset_plaintext got=%h exp=0", plaintext); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_rfc;
    int n;
    send(RK, RN, 32'd1, '0);
    wait_out(n);
    total += 4;
    if (n != 22) begin bad++; $display("FAIL rfc_latency got=%0d exp=22", n); end
    if (plaintext[511:480] !== 32'he4e7f110) begin bad++; $display("FAIL rfc_w0 got=%h exp=e4e7f110", plaintext[511:480]); end
    if (plaintext[479:448] !== 32'h15593bd1) begin bad++; $display("FAIL rfc_w1 got=%h exp=15593bd1", plaintext[479:448]); end
    if (plaintext[31:0] !== 32'h4e3c50a2) begin bad++; $display("FAIL rfc_w15 got=%h exp=4e3c50a2", plaintext[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_round_trip;
    int n;
    logic [511:0] p, c1;
    p = rnd512();
    send(RK, RN, 32'd1, p);
    wait_out(n);
    c1 = plaintext;
    @(negedge clk);
    send(RK, RN, 32'd1, c1);
    wait_out(n);
    total++;
    if (plaintext !== p) begin bad++; $display("FAIL round_trip got=%h exp=%h", plaintext, p); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int n;
    logic [511:0] pa, pb, ea;
    pa = rnd512(); pb = rnd512();
    ea = ks(RK, RN, 32'd2) ^ pa;
    out_ready = 0;
    send(RK, RN, 32'd2, pa);
    wait_out(n);
    key = RK; nonce = RN; counter = 32'd3; ciphertext = pb; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total += 3;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
      if (plaintext !== ea) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, plaintext, ea); end
      @(negedge clk);
    end
    out_ready = 1;
    send(RK, RN, 32'd3, pb);
    wait_out(n);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    time t7;
    send(RK, RN, 32'd7, rnd512());
    t7 = acc_t;
    send(RK, RN, 32'd8, rnd512());
    total++;
    if (acc_t - t7 != 220) begin bad++; $display("FAIL b2b_period got=%0t exp=220", acc_t - t7); end
    wait_out(n);
    total += 2;
    if (n != 22) begin bad++; $display("FAIL b2b_latency got=%0d exp=22", n); end
    if (plaintext === last_pt) begin bad++; $display("FAIL b2b_distinct got=%h exp!=%h", plaintext, last_pt); end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap;
    int n;
    logic [255:0] k;
    logic [95:0] nn;
    logic [511:0] p;
    k = {rnd512()}[255:0];
    nn = {$urandom, $urandom, $urandom};
    p = rnd512();
    send(k, nn, 32'hFFFFFFFF, p);
    wait_out(n);
    total++;
    if (plaintext !== (ks(k, nn, 32'hFFFFFFFF) ^ p)) begin bad++; $display("FAIL wrap got=%h exp=%h", plaintext, ks(k, nn, 32'hFFFFFFFF) ^ p); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n;
    send(RK, RN, 32'd1, rnd512());
    repeat (10) @(negedge clk);
    rst = 1;
    key = RK; nonce = RN; counter = 32'd1; ciphertext = '0; in_valid = 1;
    @(negedge clk);
    rst = 0; in_valid = 0;
    sb.delete();
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    if (plaintext !== '0) begin bad++; $display("FAIL rmid_plaintext got=%h exp=0", plaintext); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    send(RK, RN, 32'd1, '0);
    wait_out(n);
    total++;
    if (plaintext[511:480] !== 32'he4e7f110) begin bad++; $display("FAIL rmid_fresh got=%h exp=e4e7f110", plaintext[511:480]); end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_rfc;
    test_round_trip;
    test_backpressure;
    test_back_to_back;
    test_wrap;
    test_reset_mid;
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
